vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised, single-clock VGA timing generator and pixel-fetch sequencer; successor to the fixed 640x480 controller.
- Generates HS/VS/BLANK and a frame-buffer fetch request and address, then re-aligns returned pixel data to sync by a configurable fetch latency.
- Adds selectable sync polarity, runtime 2x pixel doubling, line-start pulse and frame counter.
- Sits between the frame-buffer read port and the VGA DAC pins.

Parameters:
- COLOR_W, 4, bits per colour channel
- H_FRONT, 16, horizontal front porch, pixels
- H_SYNC, 96, horizontal sync width, pixels
- H_BACK, 48, horizontal back porch, pixels
- H_ACT, 640, visible pixels per line
- V_FRONT, 10, vertical front porch, lines
- V_SYNC, 2, vertical sync width, lines
- V_BACK, 33, vertical back porch, lines
- V_ACT, 480, visible lines
- HS_POL, 0, active level of oVGA_HS
- VS_POL, 0, active level of oVGA_VS
- FETCH_LAT, 2, cycles from oRequest to valid iRed/iGreen/iBlue; legal range 0..8
- STRIDE, H_ACT, address increment per fetched row
- ADDR_W, 22, address width
- Derived: H_BLANK=H_FRONT+H_SYNC+H_BACK, H_TOTAL=H_BLANK+H_ACT; V_BLANK and V_TOTAL likewise.

Ports:
- iCLK  in  1  pixel clock; all logic on its rising edge
- iRST  in  1  synchronous reset, active-high
- iScale  in  1  0=1x, 1=2x pixel doubling; sampled only at frame start
- iRed/iGreen/iBlue  in  COLOR_W each  pixel data, valid FETCH_LAT cycles after oRequest
- oRequest  out  1  fetch strobe, high for each visible pixel
- oAddress  out  ADDR_W  fetch address
- oCurrent_X  out  11  fetch column (scaled)
- oCurrent_Y  out  11  fetch row (scaled)
- oTopOfScreen  out  1  one-cycle frame-start pulse
- oLineStart  out  1  one-cycle pulse at first visible pixel of each visible line
- oFrameCount  out  16  frames started since reset
- oVGA_R/oVGA_G/oVGA_B  out  COLOR_W each  registered colour, 0 when blanked
- oVGA_HS  out  1  horizontal sync, polarity HS_POL
- oVGA_VS  out  1  vertical sync, polarity VS_POL
- oVGA_BLANK  out  1  active-low blank
- oVGA_CLOCK  out  1  ~iCLK

Behaviour:
- Counters:
  - H counts 0..H_TOTAL-1 and wraps.
  - V increments only on the cycle H wraps and counts 0..V_TOTAL-1. No derived clocks.
  - Region ordering: front porch, sync, back porch, then active (H>=H_BLANK visible; V>=V_BLANK visible).
- Stage 0 (registered once from the counters). These outputs change one cycle after the counter value:
  - oRequest = (H>=H_BLANK && V>=V_BLANK)
  - rx = H-H_BLANK, ry = V-V_BLANK
  - Scale latched 0: X=rx, Y=ry. Scale latched 1: X=rx>>1, Y=ry>>1.
  - Outside the visible region X and Y are 0.
  - oAddress = Y*STRIDE+X, truncated to ADDR_W.
  - oTopOfScreen = (H==0 && V==0).
  - oLineStart = (H==H_BLANK && V>=V_BLANK).
- Frame start:
  - On the same edge that sets oTopOfScreen, oFrameCount increments (wraps 0xFFFF->0) and iScale is latched.
  - iScale changes mid-frame have no effect until the next frame.
- Internal sync: hs_int active when H in [H_FRONT, H_FRONT+H_SYNC); vs_int active when V in [V_FRONT, V_FRONT+V_SYNC). Both are registered in stage 0.
- Output alignment:
  - hs, vs and the visible flag pass through a FETCH_LAT+1 stage delay line after stage 0.
  - oVGA_R/G/B register the input data, masked to 0 when the delayed visible flag is low.
  - Pixel data requested at cycle t reaches the oVGA colour outputs at t+FETCH_LAT+1, coincident with its sync/blank.
  - FETCH_LAT=0 means data is sampled in the same cycle oRequest is high.
- oVGA_HS = hs_delayed ? HS_POL : ~HS_POL; oVGA_VS likewise with VS_POL; oVGA_BLANK = visible_delayed.
- Reset (any cycle, including mid-line or mid-frame):
  - Counters go to 0 and all delay stages clear.
  - oRequest, oAddress, X, Y, oTopOfScreen, oLineStart, oFrameCount and RGB all go to 0.
  - oVGA_BLANK=0; HS and VS at their inactive level; latched scale=0.
  - The first cycle after reset deassertion counts from H=0, V=0, so oTopOfScreen pulses on the next edge.
- Simultaneous events: H wrap at V=V_TOTAL-1 wraps both counters on the same edge.
- Scale-mode address repeats are expected; the source may re-serve the same word.

Test Plan:
- Default parameters, release reset, run 2 frames: oTopOfScreen pulses every 420000 cycles, first pulse 1 cycle after release; oFrameCount reads 1 then 2; oLineStart occurs 480 times per frame.
- Sync timing: oVGA_HS low exactly 96 of every 800 cycles; oVGA_VS low exactly 1600 consecutive cycles per frame; VS edges coincide with an H wrap. Repeat with HS_POL=1: HS is high for those 96 cycles.
- Latency, FETCH_LAT=2: iRed = low 4 bits of oAddress, delayed 2 cycles. oVGA_BLANK rises 3 cycles after the first oRequest of a line. oVGA_R then reads 0,1,2,...; oVGA_R=0 whenever oVGA_BLANK=0.
- Address end: at X=639, Y=479, oAddress=307199; oRequest is 0 on the next cycle; oAddress=0 outside the visible region.
- Scale: set iScale=1 mid-frame; the current frame is unchanged. Next frame: X sequence 0,0,1,1,...; last pixel oAddress=239*640+319=153279.
- Reset mid-line: pulse iRST for 1 cycle at H=400, V=100. Next cycle: all outputs at reset values, oFrameCount=0, HS/VS inactive. oTopOfScreen pulses 1 cycle after deassertion.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: frame-buffer fetch and VGA pin bundle for the timing generator
interface vga_timing_gen_if #(
    parameter int COLOR_W = 4,
    parameter int ADDR_W  = 22
);
    logic               iScale;
    logic [COLOR_W-1:0] iRed, iGreen, iBlue;
    logic               oRequest;
    logic [ADDR_W-1:0]  oAddress;
    logic [10:0]        oCurrent_X, oCurrent_Y;
    logic               oTopOfScreen, oLineStart;
    logic [15:0]        oFrameCount;
    logic [COLOR_W-1:0] oVGA_R, oVGA_G, oVGA_B;
    logic               oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK;

    modport master (
        input  iScale, iRed, iGreen, iBlue,
        output oRequest, oAddress, oCurrent_X, oCurrent_Y, oTopOfScreen, oLineStart,
               oFrameCount, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK
    );

    modport slave (
        output iScale, iRed, iGreen, iBlue,
        input  oRequest, oAddress, oCurrent_X, oCurrent_Y, oTopOfScreen, oLineStart,
               oFrameCount, oVGA_R, oVGA_G, oVGA_B, oVGA_HS, oVGA_VS, oVGA_BLANK, oVGA_CLOCK
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing and pixel-fetch sequencer with latency-aligned colour output
module vga_timing_gen #(
    parameter int COLOR_W   = 4,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int H_ACT     = 640,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int V_ACT     = 480,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int FETCH_LAT = 2,
    parameter int STRIDE    = H_ACT,
    parameter int ADDR_W    = 22
) (
    input logic              iCLK,
    input logic              iRST,
    vga_timing_gen_if.master bus
);
    localparam logic [15:0] HB  = 16'(H_FRONT + H_SYNC + H_BACK);
    localparam logic [15:0] HT  = HB + 16'(H_ACT);
    localparam logic [15:0] HS0 = 16'(H_FRONT);
    localparam logic [15:0] HS1 = 16'(H_FRONT + H_SYNC);
    localparam logic [15:0] VB  = 16'(V_FRONT + V_SYNC + V_BACK);
    localparam logic [15:0] VT  = VB + 16'(V_ACT);
    localparam logic [15:0] VS0 = 16'(V_FRONT);
    localparam logic [15:0] VS1 = 16'(V_FRONT + V_SYNC);
    localparam logic [31:0] STR = 32'(STRIDE);
    localparam logic        HP  = 1'(HS_POL);
    localparam logic        VP  = 1'(VS_POL);

    logic [15:0]        r_h, r_v, w_rx, w_ry, w_x, w_y;
    logic               w_vis, w_hwrap, w_tos;
    logic               r_scale, r_req, r_tos, r_ls, r_hs0, r_vs0;
    logic [10:0]        r_x, r_y;
    logic [ADDR_W-1:0]  r_addr;
    logic [15:0]        r_frame;
    logic [COLOR_W-1:0] r_r, r_g, r_b;
    // each stage holds {hs, vs, visible}; w_chain[k] is what stage k loads next
    logic [2:0]         r_dly [FETCH_LAT+1];
    logic [2:0]         w_chain [FETCH_LAT+1];

    always_comb begin
        w_hwrap = r_h == HT - 16'd1;
        w_tos = r_h == '0 && r_v == '0;
        w_vis = r_h >= HB && r_v >= VB;
        w_rx = r_h - HB;
        w_ry = r_v - VB;
        w_x = w_vis ? (r_scale ? w_rx >> 1 : w_rx) : '0;
        w_y = w_vis ? (r_scale ? w_ry >> 1 : w_ry) : '0;
        w_chain[0] = {r_hs0, r_vs0, r_req};
        for (int k = 0; k < FETCH_LAT; k++) w_chain[k+1] = r_dly[k];
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_h <= '0;
            r_v <= '0;
            r_scale <= 1'b0;
            r_req <= 1'b0;
            r_x <= '0;
            r_y <= '0;
            r_addr <= '0;
            r_tos <= 1'b0;
            r_ls <= 1'b0;
            r_hs0 <= 1'b0;
            r_vs0 <= 1'b0;
            r_frame <= '0;
            r_dly <= '{default: '0};
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
        end else begin
            r_h <= w_hwrap ? '0 : r_h + 16'd1;
            if (w_hwrap) r_v <= r_v == VT - 16'd1 ? '0 : r_v + 16'd1;
            r_req <= w_vis;
            r_x <= w_x[10:0];
            r_y <= w_y[10:0];
            r_addr <= ADDR_W'(32'(w_y) * STR + 32'(w_x));
            r_tos <= w_tos;
            r_ls <= r_h == HB && r_v >= VB;
            r_hs0 <= r_h >= HS0 && r_h < HS1;
            r_vs0 <= r_v >= VS0 && r_v < VS1;
            if (w_tos) begin
                r_frame <= r_frame + 16'd1;
                r_scale <= bus.iScale;
            end
            for (int k = 0; k <= FETCH_LAT; k++) r_dly[k] <= w_chain[k];
            // colour is masked by the visible flag arriving alongside it at the last stage
            r_r <= w_chain[FETCH_LAT][0] ? bus.iRed : '0;
            r_g <= w_chain[FETCH_LAT][0] ? bus.iGreen : '0;
            r_b <= w_chain[FETCH_LAT][0] ? bus.iBlue : '0;
        end
    end

    assign bus.oRequest = r_req;
    assign bus.oAddress = r_addr;
    assign bus.oCurrent_X = r_x;
    assign bus.oCurrent_Y = r_y;
    assign bus.oTopOfScreen = r_tos;
    assign bus.oLineStart = r_ls;
    assign bus.oFrameCount = r_frame;
    assign bus.oVGA_R = r_r;
    assign bus.oVGA_G = r_g;
    assign bus.oVGA_B = r_b;
    assign bus.oVGA_HS = r_dly[FETCH_LAT][2] ? HP : !HP;
    assign bus.oVGA_VS = r_dly[FETCH_LAT][1] ? VP : !VP;
    assign bus.oVGA_BLANK = r_dly[FETCH_LAT][0];
    assign bus.oVGA_CLOCK = ~iCLK;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a 15x8 total / 8x4 visible geometry, two polarity/latency builds
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.COLOR_W(4), .ADDR_W(22)) b1 ();
    vga_timing_gen_if #(.COLOR_W(4), .ADDR_W(22)) b2 ();

    vga_timing_gen #(
        .COLOR_W(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(4),
        .HS_POL(0), .VS_POL(0), .FETCH_LAT(2), .STRIDE(8), .ADDR_W(22)
    ) dut1 (.iCLK(clk), .iRST(rst), .bus(b1));

    vga_timing_gen #(
        .COLOR_W(4), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .H_ACT(8),
        .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .V_ACT(4),
        .HS_POL(1), .VS_POL(1), .FETCH_LAT(0), .STRIDE(8), .ADDR_W(22)
    ) dut2 (.iCLK(clk), .iRST(rst), .bus(b2));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stage-0 view of counter position q; frame 2 runs scaled when sc_en is set.
    task automatic mdl(input int q, input bit sc_en, output bit vis, output bit hs, output bit vs,
                       output bit tos, output bit ls, output int x, output int y, output int a);
        int h, v, s;
        if (q < 0) begin
            vis = 0; hs = 0; vs = 0; tos = 0; ls = 0; x = 0; y = 0; a = 0;
            return;
        end
        h = q % 15;
        v = (q / 15) % 8;
        s = (sc_en && q / 120 == 2) ? 1 : 0;
        vis = h >= 7 && v >= 4;
        hs = h >= 2 && h < 5;
        vs = v >= 1 && v < 3;
        tos = h == 0 && v == 0;
        ls = h == 7 && v >= 4;
        x = vis ? (h - 7) >> s : 0;
        y = vis ? (v - 4) >> s : 0;
        a = y * 8 + x;
    endtask

    bit vis, hs, vs, tos, ls;
    int x, y, a;
    logic [3:0] ea, eg, h0, h1;
    int n_tos, n_ls, n_hsl, n_vsl;

    initial begin
        b1.iScale = 0; b1.iRed = 0; b1.iGreen = 0; b1.iBlue = 4'hA;
        b2.iScale = 0; b2.iRed = 0; b2.iGreen = 4'h3; b2.iBlue = 4'hC;
        h0 = 0; h1 = 0;
        n_tos = 0; n_ls = 0; n_hsl = 0; n_vsl = 0;
        repeat (3) tick;
        chk("rst_req", b1.oRequest, 0);
        chk("rst_addr", b1.oAddress, 0);
        chk("rst_x", b1.oCurrent_X, 0);
        chk("rst_y", b1.oCurrent_Y, 0);
        chk("rst_tos", b1.oTopOfScreen, 0);
        chk("rst_ls", b1.oLineStart, 0);
        chk("rst_frame", b1.oFrameCount, 0);
        chk("rst_r", b1.oVGA_R, 0);
        chk("rst_blank", b1.oVGA_BLANK, 0);
        chk("rst_hs", b1.oVGA_HS, 1);
        chk("rst_vs", b1.oVGA_VS, 1);
        chk("rst_hs_pol1", b2.oVGA_HS, 0);
        chk("rst_vs_pol1", b2.oVGA_VS, 0);
        chk("vga_clock", b1.oVGA_CLOCK, 0);
        rst = 0;
        for (int n = 1; n <= 500; n++) begin
            int p;
            tick;
            p = n - 1;
            mdl(p, 1, vis, hs, vs, tos, ls, x, y, a);
            chk("req", b1.oRequest, vis);
            chk("addr", b1.oAddress, a);
            chk("x", b1.oCurrent_X, x);
            chk("y", b1.oCurrent_Y, y);
            chk("tos", b1.oTopOfScreen, tos);
            chk("ls", b1.oLineStart, ls);
            chk("frame", b1.oFrameCount, p / 120 + 1);
            n_tos += b1.oTopOfScreen ? 1 : 0;
            n_ls += b1.oLineStart ? 1 : 0;
            mdl(n - 4, 1, vis, hs, vs, tos, ls, x, y, a);
            ea = a[3:0];
            eg = ~ea;
            chk("hs", b1.oVGA_HS, !hs);
            chk("vs", b1.oVGA_VS, !vs);
            chk("blank", b1.oVGA_BLANK, vis);
            chk("r_lat2", b1.oVGA_R, vis ? ea : 4'h0);
            chk("g_lat2", b1.oVGA_G, vis ? eg : 4'h0);
            chk("b_lat2", b1.oVGA_B, vis ? 4'hA : 4'h0);
            n_hsl += b1.oVGA_HS ? 0 : 1;
            n_vsl += b1.oVGA_VS ? 0 : 1;
            mdl(n - 2, 0, vis, hs, vs, tos, ls, x, y, a);
            ea = a[3:0];
            chk("hs_pol1", b2.oVGA_HS, hs);
            chk("vs_pol1", b2.oVGA_VS, vs);
            chk("blank_lat0", b2.oVGA_BLANK, vis);
            chk("r_lat0", b2.oVGA_R, vis ? ea : 4'h0);
            chk("g_lat0", b2.oVGA_G, vis ? 4'h3 : 4'h0);
            chk("b_lat0", b2.oVGA_B, vis ? 4'hC : 4'h0);
            if (p == 119) chk("addr_last_1x", b1.oAddress, 31);
            if (p == 120) chk("req_after_last", b1.oRequest, 0);
            if (p == 194) chk("x_mid_frame_unscaled", b1.oCurrent_X, 7);
            if (p == 308) chk("x_2x_first", b1.oCurrent_X, 0);
            if (p == 309) chk("x_2x_second", b1.oCurrent_X, 1);
            if (p == 359) chk("addr_last_2x", b1.oAddress, 11);
            b1.iRed = h1;
            b1.iGreen = ~h1;
            h1 = h0;
            h0 = b1.oAddress[3:0];
            b2.iRed = b2.oAddress[3:0];
            if (p == 180) b1.iScale = 1;
            if (p == 300) b1.iScale = 0;
        end
        chk("tos_count", n_tos, 5);
        chk("ls_count", n_ls, 16);
        chk("hs_low_count", n_hsl, 99);
        chk("vs_low_count", n_vsl, 122);
        chk("frame_end", b1.oFrameCount, 5);
        chk("frame_end_2", b2.oFrameCount, 5);
        repeat (65) tick;
        chk("req_pre_rst", b1.oRequest, 1);
        rst = 1;
        tick;
        chk("mrst_req", b1.oRequest, 0);
        chk("mrst_addr", b1.oAddress, 0);
        chk("mrst_x", b1.oCurrent_X, 0);
        chk("mrst_y", b1.oCurrent_Y, 0);
        chk("mrst_frame", b1.oFrameCount, 0);
        chk("mrst_r", b1.oVGA_R, 0);
        chk("mrst_blank", b1.oVGA_BLANK, 0);
        chk("mrst_hs", b1.oVGA_HS, 1);
        chk("mrst_vs", b1.oVGA_VS, 1);
        chk("mrst_hs_pol1", b2.oVGA_HS, 0);
        rst = 0;
        tick;
        chk("post_rst_tos", b1.oTopOfScreen, 1);
        chk("post_rst_frame", b1.oFrameCount, 1);
        chk("post_rst_req", b1.oRequest, 0);
        tick;
        chk("post_rst_tos_end", b1.oTopOfScreen, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
